// File: rtl/gf2m_ds_mul.sv
// Digit-serial GF(2^M) multiplier: result = a*b mod (x^M + poly).
// Optional abort input when GF2M_DS_ABORT_EN is defined.
module gf2m_ds_mul #(
  parameter int DATA_WIDTH = 163,
  parameter int DIGIT      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef GF2M_DS_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] poly,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy,
  output logic                  done
);

  localparam int M  = DATA_WIDTH;
  localparam int D  = DIGIT;
  localparam int N  = (M + D - 1) / D;
  localparam int W  = N * D;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CAL  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [M-1:0]    a_q;
  logic [M-1:0]    p_q;
  logic [W-1:0]    b_q;
  logic [M-1:0]    acc_q;
  logic [CW-1:0]   cnt_q;
  logic [M-1:0]    t_next;
  logic [D-1:0]    digit;
  logic            last;
  logic            load;
  logic            fin;

  // Horner over one digit: T*x^D + A*digit, reduced each bit step.
  function automatic logic [M-1:0] step(
    input logic [M-1:0] t,
    input logic [M-1:0] x,
    input logic [M-1:0] p,
    input logic [D-1:0] dg
  );
    logic [M-1:0] r;
    r = t;
    for (int j = D - 1; j >= 0; j--) begin
      r = (r << 1)
        ^ (r[M-1] ? p : '0)
        ^ (dg[j] ? x : '0);
    end
    return r;
  endfunction

  assign digit  = b_q[W-1 -: D];
  assign t_next = step(acc_q, a_q, p_q, digit);
  assign last   = (cnt_q == CW'(N - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and load/finish strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAL;
          load    = 1'b1;
        end
      end
      CAL: begin
`ifdef GF2M_DS_ABORT_EN
        if (abort) begin
          state_d = IDLE;
        end else
`endif
        if (last) begin
          state_d = IDLE;
          fin     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, digit shift, accumulator and counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      p_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      a_q   <= a;
      p_q   <= poly;
      b_q   <= W'(b);
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == CAL) begin
      acc_q <= t_next;
      b_q   <= b_q << D;
      if (!last) cnt_q <= cnt_q + CW'(1);
    end
  end

  // Registered outputs; result holds until the next finish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (fin) result <= t_next;
      busy <= (state_d == CAL);
      done <= fin;
    end
  end

endmodule
